// File: rtl/packet_serializer.sv
// Transmit-side packet serializer: takes one BEATS-wide packet word per handshake and
// emits it MSB byte first with first/last framing, with a one-packet pending buffer.
module packet_serializer #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_W*BEATS-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_first,
    output logic                      out_last,
    input  logic                      out_enable,
    output logic                      busy
);

    localparam int PKT_W = DATA_W * BEATS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PKT_W-1:0]   shift_reg, shift_next;
    logic [PKT_W-1:0]   pend_reg, pend_next;
    logic               pend_full_reg, pend_full_next;
    logic [DATA_W-1:0]  out_data_reg, out_data_next;

    logic in_fire;
    logic beat_accept;
    logic last_accept;

    assign in_ready    = !pend_full_reg;
    assign in_fire     = in_valid && in_ready;
    assign beat_accept = (state_reg == SEND) && out_enable;
    assign last_accept = beat_accept && (cnt_reg == LAST_BEAT);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    shift_next = in_data;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (beat_accept) begin
                    // Current beat always sits in the top byte; shifting exposes the next one.
                    shift_next = {shift_reg[PKT_W-DATA_W-1:0], {DATA_W{1'b0}}};
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
                if (last_accept) begin
                    cnt_next = '0;
                    if (pend_full_reg) begin
                        shift_next     = pend_reg;
                        pend_full_next = 1'b0;
                    end else if (in_fire) begin
                        shift_next = in_data;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (in_fire) begin
                    pend_next      = in_data;
                    pend_full_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Output byte is registered so it holds through stalls and after the packet ends.
        if (state_next == SEND)
            out_data_next = shift_next[PKT_W-1 -: DATA_W];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = (state_reg == SEND);
    assign out_first = out_valid && (cnt_reg == '0);
    assign out_last  = out_valid && (cnt_reg == LAST_BEAT);
    assign busy      = (state_reg == SEND) || pend_full_reg;

endmodule

// File: tb/tb_packet_serializer.sv
// Directed self-checking bench for packet_serializer (DATA_W=8, BEATS=4).
module tb_packet_serializer;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic        out_enable;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    packet_serializer #(.DATA_W(8), .BEATS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_enable (out_enable),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Check the full output set: valid, data, first, last, busy, in_ready.
    task automatic beat(input string tag, input logic v, input logic [7:0] d,
                        input logic f, input logic l, input logic b, input logic r);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".first"}, 32'(out_first), 32'(f));
        chk({tag, ".last"},  32'(out_last),  32'(l));
        chk({tag, ".busy"},  32'(busy),      32'(b));
        chk({tag, ".ready"}, 32'(in_ready),  32'(r));
        $display("%0t %s: v=%0b data=%02h first=%0b last=%0b busy=%0b ready=%0b",
                 $time, tag, out_valid, out_data, out_first, out_last, busy, in_ready);
    endtask

    initial begin
        reset      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_enable = 1'b0;
        #12;
        beat("reset", 0, 8'h00, 0, 0, 0, 1);
        reset = 1'b1;
        cyc();

        // Single packet
        in_data = 32'hA1B2C3D4; in_valid = 1; out_enable = 1;
        cyc(); in_valid = 0;
        beat("p1.b0", 1, 8'hA1, 1, 0, 1, 1);
        cyc(); beat("p1.b1", 1, 8'hB2, 0, 0, 1, 1);
        cyc(); beat("p1.b2", 1, 8'hC3, 0, 0, 1, 1);
        cyc(); beat("p1.b3", 1, 8'hD4, 0, 1, 1, 1);
        cyc(); beat("p1.end", 0, 8'hD4, 0, 0, 0, 1);

        // Two back-to-back packets
        in_data = 32'h11223344; in_valid = 1;
        cyc(); beat("bb.b0", 1, 8'h11, 1, 0, 1, 1);
        in_data = 32'h55667788;
        cyc(); in_valid = 0;
        beat("bb.b1", 1, 8'h22, 0, 0, 1, 0);
        cyc(); beat("bb.b2", 1, 8'h33, 0, 0, 1, 0);
        cyc(); beat("bb.b3", 1, 8'h44, 0, 1, 1, 0);
        cyc(); beat("bb.b4", 1, 8'h55, 1, 0, 1, 1);
        cyc(); beat("bb.b5", 1, 8'h66, 0, 0, 1, 1);
        cyc(); beat("bb.b6", 1, 8'h77, 0, 0, 1, 1);
        cyc(); beat("bb.b7", 1, 8'h88, 0, 1, 1, 1);
        cyc(); beat("bb.end", 0, 8'h88, 0, 0, 0, 1);

        // Third word offered while both slots full
        in_data = 32'h01020304; in_valid = 1;
        cyc(); beat("fl.b0", 1, 8'h01, 1, 0, 1, 1);
        in_data = 32'h05060708;
        cyc(); beat("fl.b1", 1, 8'h02, 0, 0, 1, 0);
        in_data = 32'h090A0B0C;
        cyc(); beat("fl.b2", 1, 8'h03, 0, 0, 1, 0);
        cyc(); beat("fl.b3", 1, 8'h04, 0, 1, 1, 0);
        cyc(); beat("fl.b4", 1, 8'h05, 1, 0, 1, 1);
        cyc(); in_valid = 0;
        beat("fl.b5", 1, 8'h06, 0, 0, 1, 0);
        cyc(); beat("fl.b6", 1, 8'h07, 0, 0, 1, 0);
        cyc(); beat("fl.b7", 1, 8'h08, 0, 1, 1, 0);
        cyc(); beat("fl.b8", 1, 8'h09, 1, 0, 1, 1);
        cyc(); beat("fl.b9", 1, 8'h0A, 0, 0, 1, 1);
        cyc(); beat("fl.b10", 1, 8'h0B, 0, 0, 1, 1);
        cyc(); beat("fl.b11", 1, 8'h0C, 0, 1, 1, 1);
        cyc(); beat("fl.end", 0, 8'h0C, 0, 0, 0, 1);

        // Stalls via out_enable
        in_data = 32'hDEADBEEF; in_valid = 1; out_enable = 1;
        cyc(); in_valid = 0;
        beat("st.b0", 1, 8'hDE, 1, 0, 1, 1);
        cyc(); beat("st.b1", 1, 8'hAD, 0, 0, 1, 1);
        out_enable = 0;
        cyc(); beat("st.h1", 1, 8'hAD, 0, 0, 1, 1);
        cyc(); beat("st.h2", 1, 8'hAD, 0, 0, 1, 1);
        out_enable = 1;
        cyc(); beat("st.b2", 1, 8'hBE, 0, 0, 1, 1);
        out_enable = 0;
        cyc(); beat("st.h3", 1, 8'hBE, 0, 0, 1, 1);
        out_enable = 1;
        cyc(); beat("st.b3", 1, 8'hEF, 0, 1, 1, 1);
        out_enable = 0;
        cyc(); beat("st.h4", 1, 8'hEF, 0, 1, 1, 1);
        out_enable = 1;
        cyc(); beat("st.end", 0, 8'hEF, 0, 0, 0, 1);

        // Input arriving exactly on last-beat acceptance, pending empty
        in_data = 32'h10203040; in_valid = 1;
        cyc(); in_valid = 0;
        beat("nb.b0", 1, 8'h10, 1, 0, 1, 1);
        cyc(); beat("nb.b1", 1, 8'h20, 0, 0, 1, 1);
        cyc(); beat("nb.b2", 1, 8'h30, 0, 0, 1, 1);
        cyc(); beat("nb.b3", 1, 8'h40, 0, 1, 1, 1);
        in_data = 32'h50607080; in_valid = 1;
        cyc(); in_valid = 0;
        beat("nb.b4", 1, 8'h50, 1, 0, 1, 1);
        cyc(); beat("nb.b5", 1, 8'h60, 0, 0, 1, 1);
        cyc(); beat("nb.b6", 1, 8'h70, 0, 0, 1, 1);
        cyc(); beat("nb.b7", 1, 8'h80, 0, 1, 1, 1);
        cyc(); beat("nb.end", 0, 8'h80, 0, 0, 0, 1);

        // Asynchronous reset mid-packet with pending loaded
        in_data = 32'hCAFEF00D; in_valid = 1;
        cyc(); beat("rs.b0", 1, 8'hCA, 1, 0, 1, 1);
        in_data = 32'h11111111;
        cyc(); in_valid = 0;
        beat("rs.b1", 1, 8'hFE, 0, 0, 1, 0);
        #2 reset = 1'b0;
        #1 beat("rs.async", 0, 8'h00, 0, 0, 0, 1);
        cyc(); reset = 1'b1;
        cyc(); beat("rs.idle1", 0, 8'h00, 0, 0, 0, 1);
        cyc(); beat("rs.idle2", 0, 8'h00, 0, 0, 0, 1);
        cyc(); beat("rs.idle3", 0, 8'h00, 0, 0, 0, 1);
        in_data = 32'h99AABBCC; in_valid = 1;
        cyc(); in_valid = 0;
        beat("rs.new0", 1, 8'h99, 1, 0, 1, 1);
        cyc(); beat("rs.new1", 1, 8'hAA, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
